// File: rtl/shift_unit_pipe_if.sv
// shift_unit_pipe_if
// Request/response bundle for the pipelined barrel shifter.
//   in_valid/in_ready   : operation handshake (producer -> shifter)
//   in_op               : 00 SLL, 01 SRL, 10 SRA, 11 pass
//   in_word             : 1 = 32-bit word variant, result sign-extended
//   in_shamt/in_data    : shift amount and operand
//   in_tag              : sideband returned unchanged with the result
//   out_valid/out_ready : result handshake (shifter -> consumer)
//   out_data/out_tag    : result and its tag
// The slave modport is the shifter side, master is the producer/consumer side.
interface shift_unit_pipe_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
);
  localparam int SHW = $clog2(XLEN);

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic             in_word;
  logic [SHW-1:0]   in_shamt;
  logic [XLEN-1:0]  in_data;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_data;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_op, in_word, in_shamt, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );

  modport master (
    output in_valid, in_op, in_word, in_shamt, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/shift_unit_pipe.sv
// shift_unit_pipe
// Pipelined barrel shifter (SLL/SRL/SRA/pass, plus 32-bit word variants).
// The log2(XLEN) shift levels are split across STAGES register stages,
// earlier stages taking any extra levels. The last stage is the output
// register. One global advance signal moves the whole pipe; bubbles are
// not collapsed.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset (clears valids and output regs)
//   bus  : shift_unit_pipe_if.slave (in_* request, out_* response)
module shift_unit_pipe #(
  parameter int XLEN   = 64,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic            clk,
  input  logic            rst,
  shift_unit_pipe_if.slave bus
);
  localparam int SHW   = $clog2(XLEN);
  localparam int WLEN  = (XLEN < 32) ? XLEN : 32;
  localparam int BASE  = SHW / STAGES;
  localparam int EXTRA = SHW % STAGES;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  // First shift level handled by stage s.
  function automatic int lvl_lo(input int s);
    return s * BASE + ((s < EXTRA) ? s : EXTRA);
  endfunction

  // Apply shift levels [lo, hi) selected by amt. Right shifts pull in 'fill'.
  function automatic logic [XLEN-1:0] shift_levels(
    input logic [XLEN-1:0] x,
    input logic [SHW-1:0]  amt,
    input logic            left,
    input logic            fill,
    input int              lo,
    input int              hi
  );
    logic [XLEN-1:0]   r;
    logic [2*XLEN-1:0] w;
    r = x;
    for (int l = 0; l < SHW; l++) begin
      if (l >= lo && l < hi && amt[l]) begin
        if (left) begin
          r = r << (1 << l);
        end else begin
          w = {{XLEN{fill}}, r} >> (1 << l);
          r = w[XLEN-1:0];
        end
      end
    end
    return r;
  endfunction

  function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] x);
    logic [XLEN-1:0] r;
    r = x;
    for (int b = WLEN; b < XLEN; b++) r[b] = x[WLEN-1];
    return r;
  endfunction

  logic            adv;
  logic            out_valid;
  logic [XLEN-1:0] pre_data;
  logic [SHW-1:0]  pre_shamt;
  logic            pre_left;
  logic            pre_fill;

  // Operand conditioning. In word mode the upper bits are rebuilt from the
  // low word (sign copy for SRA, zeros otherwise) so a full-width shift
  // produces the right low word; the fill bit then falls out of the MSB.
  always_comb begin
    pre_data  = bus.in_data;
    pre_shamt = bus.in_shamt;
    pre_left  = (bus.in_op == OP_SLL);
    if (bus.in_word) begin
      for (int b = WLEN; b < XLEN; b++)
        pre_data[b] = (bus.in_op == OP_SRA) ? bus.in_data[WLEN-1] : 1'b0;
      pre_shamt = bus.in_shamt & SHW'(WLEN - 1);
    end
    if (bus.in_op == OP_PASS) pre_shamt = '0;
    pre_fill = (bus.in_op == OP_SRA) && pre_data[XLEN-1];
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO = lvl_lo(gi);
    localparam int HI = lvl_lo(gi + 1);

    logic             src_valid;
    logic             src_left;
    logic             src_fill;
    logic             src_word;
    logic [XLEN-1:0]  src_data;
    logic [SHW-1:0]   src_shamt;
    logic [TAG_W-1:0] src_tag;
    logic [XLEN-1:0]  shifted;
    logic             valid_d;
    logic             valid_q;

    if (gi == 0) begin : g_src
      assign src_valid = bus.in_valid && adv;
      assign src_data  = pre_data;
      assign src_shamt = pre_shamt;
      assign src_left  = pre_left;
      assign src_fill  = pre_fill;
      assign src_word  = bus.in_word;
      assign src_tag   = bus.in_tag;
    end else begin : g_src
      assign src_valid = g_stage[gi-1].valid_q;
      assign src_data  = g_stage[gi-1].g_mid.data_q;
      assign src_shamt = g_stage[gi-1].g_mid.shamt_q;
      assign src_left  = g_stage[gi-1].g_mid.left_q;
      assign src_fill  = g_stage[gi-1].g_mid.fill_q;
      assign src_word  = g_stage[gi-1].g_mid.word_q;
      assign src_tag   = g_stage[gi-1].g_mid.tag_q;
    end

    assign shifted = shift_levels(src_data, src_shamt, src_left, src_fill, LO, HI);

    always_comb begin
      valid_d = valid_q;
      if (adv) valid_d = src_valid;
    end

    always_ff @(posedge clk) begin
      if (rst) valid_q <= 1'b0;
      else     valid_q <= valid_d;
    end

    if (gi < STAGES - 1) begin : g_mid
      // Intermediate stage: mode, word flag and tag ride along with data.
      logic [XLEN-1:0]  data_d,  data_q;
      logic [SHW-1:0]   shamt_d, shamt_q;
      logic             left_d,  left_q;
      logic             fill_d,  fill_q;
      logic             word_d,  word_q;
      logic [TAG_W-1:0] tag_d,   tag_q;

      always_comb begin
        data_d  = data_q;
        shamt_d = shamt_q;
        left_d  = left_q;
        fill_d  = fill_q;
        word_d  = word_q;
        tag_d   = tag_q;
        if (adv) begin
          data_d  = shifted;
          shamt_d = src_shamt;
          left_d  = src_left;
          fill_d  = src_fill;
          word_d  = src_word;
          tag_d   = src_tag;
        end
      end

      always_ff @(posedge clk) begin
        data_q  <= data_d;
        shamt_q <= shamt_d;
        left_q  <= left_d;
        fill_q  <= fill_d;
        word_q  <= word_d;
        tag_q   <= tag_d;
      end
    end else begin : g_last
      // Output stage: word results are sign-extended on the way in.
      logic [XLEN-1:0]  data_d, data_q;
      logic [TAG_W-1:0] tag_d,  tag_q;

      always_comb begin
        data_d = data_q;
        tag_d  = tag_q;
        if (adv) begin
          data_d = src_word ? sext_word(shifted) : shifted;
          tag_d  = src_tag;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          data_q <= '0;
          tag_q  <= '0;
        end else begin
          data_q <= data_d;
          tag_q  <= tag_d;
        end
      end
    end
  end

  assign out_valid    = g_stage[STAGES-1].valid_q;
  // The pipe moves whenever the output slot is empty or being drained.
  assign adv          = !out_valid || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = g_stage[STAGES-1].g_last.data_q;
  assign bus.out_tag   = g_stage[STAGES-1].g_last.tag_q;
endmodule

// File: tb/tb_shift_unit_pipe.sv
// tb_shift_unit_pipe
// Scoreboard bench: the driver pushes the expected result when an op is
// accepted; an independent monitor pops and compares on every output
// transfer. Directed cases use literal expected values, the random sweep
// uses a plain-arithmetic reference model.
module tb_shift_unit_pipe;
  localparam int XLEN   = 64;
  localparam int STAGES = 2;
  localparam int TAG_W  = 5;
  localparam int SHW    = $clog2(XLEN);

  typedef struct packed {
    logic [XLEN-1:0]  data;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_unit_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  shift_unit_pipe #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t exp_q[$];
  int   n_checks  = 0;
  int   n_pass    = 0;
  int   n_retired = 0;
  int   last_waits;
  bit   ready_rand = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  // Reference model: RISC-V shift semantics in plain arithmetic.
  function automatic logic [XLEN-1:0] ref_model(input logic [1:0] op, input logic word,
                                                input logic [SHW-1:0] shamt,
                                                input logic [XLEN-1:0] d);
    logic [31:0]            w;
    logic signed [31:0]     ws;
    logic signed [XLEN-1:0] ds;
    int                     s;
    if (word) begin
      s  = int'(shamt % 32);
      w  = d[31:0];
      ws = w;
      case (op)
        2'd0:    w = w << s;
        2'd1:    w = w >> s;
        2'd2:    w = ws >>> s;
        default: w = d[31:0];
      endcase
      return {{(XLEN-32){w[31]}}, w};
    end
    s  = int'(shamt);
    ds = d;
    case (op)
      2'd0:    return d << s;
      2'd1:    return d >> s;
      2'd2:    return ds >>> s;
      default: return d;
    endcase
  endfunction

  // Present an op starting just after a rising edge; push its expected
  // result at the negedge where the handshake is seen to complete.
  task automatic issue_exp(input logic [1:0] op, input logic word, input logic [SHW-1:0] shamt,
                           input logic [XLEN-1:0] data, input logic [TAG_W-1:0] tag,
                           input logic [XLEN-1:0] exp_data);
    bit   done;
    exp_t e;
    done        = 1'b0;
    last_waits  = 0;
    bus.in_op    = op;
    bus.in_word  = word;
    bus.in_shamt = shamt;
    bus.in_data  = data;
    bus.in_tag   = tag;
    bus.in_valid = 1'b1;
    while (!done && last_waits < 1000) begin
      @(negedge clk);
      if (bus.in_ready && !rst) begin
        e.data = exp_data;
        e.tag  = tag;
        exp_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      if (!done) last_waits++;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL issue_timeout: tag %0d not accepted in %0d cycles, required acceptance", tag, last_waits);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic word, input logic [SHW-1:0] shamt,
                       input logic [XLEN-1:0] data, input logic [TAG_W-1:0] tag);
    issue_exp(op, word, shamt, data, tag, ref_model(op, word, shamt, data));
  endtask

  // Monitor: every output transfer must match the head of the scoreboard.
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_output: got data %h tag %0d, required no output", bus.out_data, bus.out_tag);
      end else begin
        mon_e = exp_q.pop_front();
        n_retired++;
        $display("retire %0d: tag=%0d data=%h expected=%h", n_retired, bus.out_tag, bus.out_data, mon_e.data);
        check("out_data", bus.out_data, mon_e.data);
        check("out_tag", 64'(bus.out_tag), 64'(mon_e.tag));
      end
    end
  end

  // Random back-pressure, only while the sweep is running.
  always @(posedge clk) begin
    #1;
    if (ready_rand) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: run exceeded cycle budget, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [XLEN-1:0]  a_data, a_exp;
    logic [1:0]       r_op;
    logic             r_word;
    logic [SHW-1:0]   r_shamt;
    logic [TAG_W-1:0] r_tag;

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_op    = 2'd0;
    bus.in_word  = 1'b0;
    bus.in_shamt = '0;
    bus.in_data  = '0;
    bus.in_tag   = '0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", bus.out_data, 64'd0);
    check("rst_out_tag", 64'(bus.out_tag), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // SRA by 63 of the sign bit, with exact two-cycle latency
    issue_exp(2'b10, 1'b0, 6'd63, 64'h8000_0000_0000_0000, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    check("lat_cycle1_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check("lat_cycle2_valid", 64'(bus.out_valid), 64'd1);
    @(posedge clk);
    #1;

    // Word variants: effective shift is shamt[4:0]
    issue_exp(2'b01, 1'b1, 6'h21, 64'h0000_0000_8000_0000, 5'd3, 64'h0000_0000_4000_0000);
    issue_exp(2'b10, 1'b1, 6'h21, 64'h0000_0000_8000_0000, 5'd4, 64'hFFFF_FFFF_C000_0000);
    issue_exp(2'b00, 1'b1, 6'd31, 64'hFFFF_FFFF_0000_0001, 5'd5, 64'hFFFF_FFFF_8000_0000);
    issue_exp(2'b11, 1'b1, 6'd9,  64'h1234_5678_8765_4321, 5'd6, 64'hFFFF_FFFF_8765_4321);
    issue_exp(2'b01, 1'b0, 6'd63, 64'h8000_0000_0000_0000, 5'd8, 64'h0000_0000_0000_0001);
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back mixed ops, one result per cycle in order
    issue_exp(2'b00, 1'b0, 6'd4, 64'h0F, 5'd1, 64'hF0);
    issue_exp(2'b01, 1'b0, 6'd4, 64'h0F, 5'd2, 64'h00);
    issue_exp(2'b10, 1'b0, 6'd4, 64'h0F, 5'd3, 64'h00);
    issue_exp(2'b11, 1'b0, 6'd4, 64'h0F, 5'd4, 64'h0F);
    @(negedge clk);
    check("b2b_valid_op3", 64'(bus.out_valid), 64'd1);
    @(negedge clk);
    check("b2b_valid_op4", 64'(bus.out_valid), 64'd1);
    @(negedge clk);
    check("b2b_drained", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;

    // Back-pressure: three ops, output held for five cycles
    bus.out_ready = 1'b0;
    a_data = 64'h0123_4567_89AB_CDEF;
    a_exp  = ref_model(2'b00, 1'b0, 6'd8, a_data);
    issue(2'b00, 1'b0, 6'd8, a_data, 5'd10);
    issue(2'b01, 1'b0, 6'd4, 64'hFEDC_BA98_7654_3210, 5'd11);
    bus.in_op    = 2'b10;
    bus.in_word  = 1'b0;
    bus.in_shamt = 6'd12;
    bus.in_data  = 64'h8765_4321_0FED_CBA9;
    bus.in_tag   = 5'd12;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", 64'(bus.in_ready), 64'd0);
      check("stall_out_valid", 64'(bus.out_valid), 64'd1);
      check("stall_out_data", bus.out_data, a_exp);
      check("stall_out_tag", 64'(bus.out_tag), 64'd10);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    issue(2'b10, 1'b0, 6'd12, 64'h8765_4321_0FED_CBA9, 5'd12);
    repeat (4) @(posedge clk);
    #1;

    // Reset with two ops in flight, and a new op presented during reset
    issue(2'b00, 1'b0, 6'd1, 64'h1111_2222_3333_4444, 5'd20);
    issue(2'b01, 1'b0, 6'd2, 64'h5555_6666_7777_8888, 5'd21);
    rst = 1'b1;
    exp_q.delete();
    bus.in_op    = 2'b11;
    bus.in_data  = 64'hDEAD_BEEF_DEAD_BEEF;
    bus.in_tag   = 5'd31;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_out_data", bus.out_data, 64'd0);
    check("midrst_out_tag", 64'(bus.out_tag), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    issue(2'b00, 1'b1, 6'd3, 64'h0000_0000_1000_0001, 5'd22);
    check("midrst_accept_waits", 64'(last_waits), 64'd0);
    repeat (4) @(posedge clk);
    #1;

    // Random sweep against the reference model with random back-pressure
    ready_rand = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      r_op   = 2'($urandom_range(0, 3));
      r_word = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0:       r_shamt = 6'd0;
        1:       r_shamt = 6'd63;
        2:       r_shamt = 6'd31;
        3:       r_shamt = 6'd32;
        default: r_shamt = SHW'($urandom_range(0, 63));
      endcase
      r_tag = TAG_W'($urandom);
      issue(r_op, r_word, r_shamt, {$urandom, $urandom}, r_tag);
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    ready_rand = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/shift_unit_pipe.md
Name: shift_unit_pipe

Overview:
- Parametrised, pipelined barrel shifter for the RV64 ULA; successor to the single-mode combinational arithmetic right shifter.
- Implements SLL, SRL and SRA, with optional 32-bit word variants (SLLW/SRLW/SRAW) that sign-extend their result.
- Splits the log2(XLEN) shift levels across configurable register stages behind a valid/ready handshake, so it can sit in the execute stage with back-pressure from writeback.

Parameters:
- XLEN, 64, datapath width; power of two, >= 8.
- STAGES, 2, pipeline register stages, 1..$clog2(XLEN). Shift levels are distributed as evenly as possible; earlier stages take the extra levels.
- TAG_W, 5, width of the sideband tag carried with each operation (destination register index).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation presented
- in_ready  out  1  unit accepts the operation this cycle
- in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 pass (data unchanged)
- in_word  in  1  1 = 32-bit word variant
- in_shamt  in  $clog2(XLEN)  shift amount
- in_data  in  XLEN  operand
- in_tag  in  TAG_W  sideband, returned unchanged
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  XLEN  result
- out_tag  out  TAG_W  tag of the result

Behaviour:
- Single clock domain. Reset is synchronous and active-high: rst sampled high at a clk rising edge clears every stage valid bit. Stage data and tag registers are not reset.
- Outputs during and after reset: out_valid=0, out_data=0, out_tag=0. Output data and tag registers are the only reset data registers. in_ready is 1 in the cycle after reset.
- Handshake and stall:
  - Global advance: adv = !out_valid || out_ready.
  - in_ready = adv. It is purely combinational from out_valid and out_ready; it never depends on in_valid.
  - When adv=1, all stages shift forward by one. Stage 0 captures in_valid && in_ready.
  - When adv=0, all stages hold, including out_data and out_tag.
  - Bubbles are not collapsed. Pipeline occupancy is at most STAGES.
- Latency: the result appears on out_* exactly STAGES cycles after acceptance when there are no stalls. Throughput is one operation per cycle.
- Output stability: out_data and out_tag hold stable while out_valid=1 and out_ready=0.
- Effective shift amount:
  - in_word=0: full in_shamt.
  - in_word=1: in_shamt[4:0]; upper bits are ignored.
- Fill bits:
  - SLL: zeros enter from the LSB.
  - SRL: zeros enter from the MSB.
  - SRA, in_word=0: in_data[XLEN-1] enters from the MSB.
  - SRA, in_word=1: in_data[31] enters from the MSB.
- Word mode:
  - The low 32 bits of in_data are the operand; upper bits are ignored.
  - The 32-bit result is sign-extended from bit 31 to XLEN. This applies to all ops, including SRL (SRLW semantics).
  - Pass with in_word=1 returns in_data[31:0] sign-extended.
- Pass op (11): the effective shift is forced to 0. Sign-extension still applies in word mode.
- Boundaries:
  - shamt=0 returns the operand (word mode: sign-extended).
  - shamt=XLEN-1 and shamt=31 in word mode must be exact.
  - Per-stage mode, word flag and tag travel with the data, so back-to-back mixed ops do not interfere.
- Simultaneous events:
  - in_valid with out_valid && out_ready in the same cycle: the new op is accepted and the old result retires.
  - rst with in_valid: reset wins, and nothing is accepted.
- Reset mid-operation: all in-flight ops are discarded. No result for them ever appears.

Test Plan:
- SRA, XLEN=64, data=0x8000_0000_0000_0000, shamt=63 -> out_data=0xFFFF_FFFF_FFFF_FFFF after exactly 2 cycles, tag preserved.
- SRLW data=0x0000_0000_8000_0000, shamt=0x21 (effective 1) -> 0x0000_0000_4000_0000. Then SRAW with the same inputs -> 0xFFFF_FFFF_C000_0000.
- Issue SLL, SRL, SRA, pass on 4 consecutive cycles with data=0x0F, shamt=4, tags 1..4 -> results 0xF0, 0x00, 0x00, 0x0F in order with tags 1..4, one per cycle.
- Hold out_ready=0 for 5 cycles with 3 ops issued -> in_ready drops once the output is valid, out_data and out_tag stay stable, no op is lost or duplicated after release.
- Assert rst with 2 ops in flight -> out_valid=0 next cycle and out_data=0; the in-flight ops never appear; a new op is accepted the following cycle.
- Random sweep, 10k ops with random op/word/shamt/ready against a reference model -> zero mismatches, order preserved.
